// File: rtl/serial_link_boot_seq_if.sv
// serial_link_boot_seq_if
//   APB bundle between the boot sequencer (master) and the serial link
//   register file (slave).
//   paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o : master -> slave
//   pready_i, prdata_i, pslverr_i                           : slave -> master
interface serial_link_boot_seq_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);
  logic [AddrWidth-1:0]     paddr_o;
  logic                     psel_o;
  logic                     penable_o;
  logic                     pwrite_o;
  logic [DataWidth-1:0]     pwdata_o;
  logic [DataWidth/8-1:0]   pstrb_o;
  logic                     pready_i;
  logic [DataWidth-1:0]     prdata_i;
  logic                     pslverr_i;

  modport master (
    output paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
    input  pready_i, prdata_i, pslverr_i
  );

  modport slave (
    input  paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
    output pready_i, prdata_i, pslverr_i
  );
endinterface

// File: rtl/serial_link_boot_seq.sv
// serial_link_boot_seq
//   APB master that brings a serial link out of reset on its own:
//   CTRL=0x300, 0x302, 0x303, settle wait, CTRL=0x003, then polls ISOLATED
//   until it reads zero.
//
// Ports
//   clk_i    : system clock
//   rst_ni   : asynchronous active-low reset
//   start_i  : one-cycle launch pulse, ignored while busy_o=1
//   busy_o   : sequence in progress
//   done_o   : sticky, link ready; cleared by the next accepted start_i
//   error_o  : sticky, pslverr (or poll timeout) seen; cleared by next start_i
//   apb      : APB master port (serial_link_boot_seq_if.master)
//
// Optional build macro
//   SERIAL_LINK_BOOT_SEQ_TIMEOUT_EN : bound the ISOLATED polling to PollLimit
//   non-zero reads, then flag error_o. Undefined: poll indefinitely.
//
// FSM states
//   state  | meaning
//   IDLE   | after reset, waiting for start_i
//   SETUP  | APB setup phase of the current step
//   ACCESS | APB access phase, waiting for pready_i
//   SETTLE | idle bus, counting SettleCycles after clock enable
//   DONE   | link de-isolated, done_o=1
//   ERROR  | pslverr or poll timeout, error_o=1
module serial_link_boot_seq #(
  parameter int unsigned AddrWidth         = 32,
  parameter int unsigned DataWidth         = 32,
  parameter logic [31:0] BaseAddr          = 32'h0,
  parameter logic [31:0] CtrlRegOffset     = 32'h0,
  parameter logic [31:0] IsolatedRegOffset = 32'h8,
  parameter int unsigned SettleCycles      = 50,
  parameter int unsigned PollLimit         = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o,
  serial_link_boot_seq_if.master apb
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    SETTLE,
    DONE,
    ERROR
  } state_e;

  // Zero settle cycles would give a zero-width counter; keep one bit.
  localparam int unsigned SettleW =
    (SettleCycles > 0) ? $clog2(SettleCycles + 1) : 1;
  localparam logic [SettleW-1:0] SettleLoad =
    (SettleCycles > 0) ? SettleW'(SettleCycles - 1) : '0;

  localparam logic [AddrWidth-1:0] CtrlAddr = AddrWidth'(BaseAddr + CtrlRegOffset);
  localparam logic [AddrWidth-1:0] IsoAddr  = AddrWidth'(BaseAddr + IsolatedRegOffset);

  localparam logic [2:0] StepPoll = 3'd4;

  state_e               state_q, state_d;
  logic [2:0]           step_q, step_d;
  logic [SettleW-1:0]   settle_q, settle_d;

`ifdef SERIAL_LINK_BOOT_SEQ_TIMEOUT_EN
  localparam int unsigned PollW = (PollLimit > 0) ? $clog2(PollLimit + 1) : 1;
  // Compare against the last allowed count so the counter never wraps.
  localparam logic [PollW-1:0] PollLast = (PollLimit > 0) ? PollW'(PollLimit - 1) : '0;
  logic [PollW-1:0]     poll_q, poll_d;
`endif

  logic [AddrWidth-1:0] step_addr;
  logic [DataWidth-1:0] step_wdata;
  logic                 step_write;
  logic                 in_xfer;

  // Transfer decode for the current step.
  always_comb begin
    step_addr  = CtrlAddr;
    step_wdata = '0;
    step_write = 1'b1;
    case (step_q)
      3'd0:    step_wdata = DataWidth'(32'h300);
      3'd1:    step_wdata = DataWidth'(32'h302);
      3'd2:    step_wdata = DataWidth'(32'h303);
      3'd3:    step_wdata = DataWidth'(32'h003);
      default: begin
        step_addr  = IsoAddr;
        step_write = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      step_q   <= '0;
      settle_q <= '0;
`ifdef SERIAL_LINK_BOOT_SEQ_TIMEOUT_EN
      poll_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      settle_q <= settle_d;
`ifdef SERIAL_LINK_BOOT_SEQ_TIMEOUT_EN
      poll_q   <= poll_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    settle_d = settle_q;
`ifdef SERIAL_LINK_BOOT_SEQ_TIMEOUT_EN
    poll_d   = poll_q;
`endif
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start_i) begin
          step_d  = '0;
`ifdef SERIAL_LINK_BOOT_SEQ_TIMEOUT_EN
          poll_d  = '0;
`endif
          state_d = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (apb.pready_i) begin
          if (apb.pslverr_i) begin
            state_d = ERROR;
          end else if (step_q == 3'd2) begin
            if (SettleCycles == 0) begin
              step_d  = 3'd3;
              state_d = SETUP;
            end else begin
              settle_d = SettleLoad;
              state_d  = SETTLE;
            end
          end else if (step_q == StepPoll) begin
            if (apb.prdata_i == '0) begin
              state_d = DONE;
            end else begin
`ifdef SERIAL_LINK_BOOT_SEQ_TIMEOUT_EN
              if (poll_q == PollLast) begin
                state_d = ERROR;
              end else begin
                poll_d  = poll_q + 1'b1;
                state_d = SETUP;
              end
`else
              state_d = SETUP;
`endif
            end
          end else begin
            step_d  = step_q + 3'd1;
            state_d = SETUP;
          end
        end
      end
      SETTLE: begin
        if (settle_q == '0) begin
          step_d  = 3'd3;
          state_d = SETUP;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from the state register so an async reset
  // drops the bus immediately.
  assign in_xfer       = (state_q == SETUP) || (state_q == ACCESS);
  assign apb.psel_o    = in_xfer;
  assign apb.penable_o = (state_q == ACCESS);
  assign apb.paddr_o   = in_xfer ? step_addr : '0;
  assign apb.pwrite_o  = in_xfer & step_write;
  assign apb.pwdata_o  = (in_xfer && step_write) ? step_wdata : '0;
  // Strobes are all ones for every transfer; held low off-bus so that the
  // whole port reads zero out of reset.
  assign apb.pstrb_o   = in_xfer ? '1 : '0;

  assign busy_o  = in_xfer || (state_q == SETTLE);
  assign done_o  = (state_q == DONE);
  assign error_o = (state_q == ERROR);

endmodule

// File: tb/tb_serial_link_boot_seq.sv
module tb_serial_link_boot_seq;
  localparam int          SETTLE     = 50;
  localparam int          POLL_LIMIT = 4;
  localparam logic [31:0] BASE       = 32'h4000_0000;
  localparam logic [31:0] CTRL_ADDR  = BASE;
  localparam logic [31:0] ISO_ADDR   = BASE + 32'h8;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  logic clk_i   = 1'b0;
  logic rst_ni  = 1'b0;
  logic start_i = 1'b0;
  logic busy_o, done_o, error_o;

  serial_link_boot_seq_if #(.AddrWidth(32), .DataWidth(32)) apb ();

  serial_link_boot_seq #(
    .AddrWidth(32), .DataWidth(32), .BaseAddr(BASE),
    .CtrlRegOffset(32'h0), .IsolatedRegOffset(32'h8),
    .SettleCycles(SETTLE), .PollLimit(POLL_LIMIT)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .apb(apb.master)
  );

  always #5 clk_i = ~clk_i;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  xfer_t       obs_q[$];
  xfer_t       exp_q[$];
  int          setup_cyc_q[$];
  int          wait_log[$];
  logic [31:0] rd_q[$];
  logic [31:0] resp_q[$];
  logic [31:0] rd_default = 32'h0;
  int          cyc = 0;
  int          psel_cycles = 0;
  int          fixed_wait = 0;
  bit          rand_wait = 1'b0;
  int          err_at = -1;
  int          xfer_n = 0;
  int          wcnt = 0;
  logic [31:0] cap_addr, cap_wdata;
  logic        cap_wr;
  logic [31:0] rdv;
  xfer_t       mon_t;
  bit          exp_done;
  int          lat, exp_lat;
  bit          tmo;

  // APB slave model plus bus monitor, evaluated on the falling edge.
  always @(negedge clk_i) begin
    cyc++;
    if (apb.psel_o) psel_cycles++;
    if (apb.psel_o && !apb.penable_o) begin
      setup_cyc_q.push_back(cyc);
      cap_addr  = apb.paddr_o;
      cap_wdata = apb.pwdata_o;
      cap_wr    = apb.pwrite_o;
      wcnt      = rand_wait ? int'($urandom_range(0, 3)) : fixed_wait;
      wait_log.push_back(wcnt);
      apb.pready_i  = 1'b0;
      apb.pslverr_i = 1'b0;
      apb.prdata_i  = '0;
    end else if (apb.psel_o && apb.penable_o) begin
      vectors++;
      if (apb.paddr_o !== cap_addr || apb.pwrite_o !== cap_wr || apb.pwdata_o !== cap_wdata) begin
        miscompares++;
        $display("FAIL access_stable: got addr=%h wr=%0b wdata=%h, want addr=%h wr=%0b wdata=%h",
                 apb.paddr_o, apb.pwrite_o, apb.pwdata_o, cap_addr, cap_wr, cap_wdata);
      end
      if (wcnt == 0) begin
        mon_t.wr   = apb.pwrite_o;
        mon_t.addr = apb.paddr_o;
        apb.pready_i  = 1'b1;
        apb.pslverr_i = (xfer_n == err_at);
        if (!apb.pwrite_o) begin
          rdv = (rd_q.size() > 0) ? rd_q.pop_front() : rd_default;
          apb.prdata_i = rdv;
          mon_t.data   = rdv;
          vectors++;
          if (apb.pwdata_o !== 32'h0) begin
            miscompares++;
            $display("FAIL read_pwdata: got %h, want 0", apb.pwdata_o);
          end
        end else begin
          apb.prdata_i = '0;
          mon_t.data   = apb.pwdata_o;
        end
        vectors++;
        if (apb.pstrb_o !== 4'hf) begin
          miscompares++;
          $display("FAIL pstrb: got %h, want f", apb.pstrb_o);
        end
        obs_q.push_back(mon_t);
        xfer_n++;
      end else begin
        wcnt--;
        apb.pready_i = 1'b0;
      end
    end else begin
      apb.pready_i  = 1'b0;
      apb.pslverr_i = 1'b0;
      apb.prdata_i  = '0;
    end
  end

  // Reference: the transfer list the sequence must produce for a given
  // ISOLATED response stream and an optional failing transfer index.
  task automatic build_exp(input logic [31:0] resp[$], input logic [31:0] dflt,
                           input int err_idx, output bit done_exp);
    logic [31:0] wvals[4];
    logic [31:0] v;
    int idx = 0;
    int nonzero = 0;
    xfer_t t;
    wvals[0] = 32'h300; wvals[1] = 32'h302; wvals[2] = 32'h303; wvals[3] = 32'h003;
    exp_q.delete();
    done_exp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      t.wr = 1'b1; t.addr = CTRL_ADDR; t.data = wvals[i];
      exp_q.push_back(t);
      if (idx == err_idx) return;
      idx++;
    end
    while (nonzero < 200) begin
      v = (resp.size() > 0) ? resp.pop_front() : dflt;
      t.wr = 1'b0; t.addr = ISO_ADDR; t.data = v;
      exp_q.push_back(t);
      if (idx == err_idx) return;
      idx++;
      if (v == 32'h0) begin
        done_exp = 1'b1;
        return;
      end
      nonzero++;
`ifdef SERIAL_LINK_BOOT_SEQ_TIMEOUT_EN
      if (nonzero == POLL_LIMIT) return;
`endif
    end
  endtask

  task automatic clear_obs();
    obs_q.delete();
    setup_cyc_q.delete();
    wait_log.delete();
    xfer_n = 0;
    psel_cycles = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_end(input int first, input int bound, output int l, output bit to);
    l = first;
    while (!(done_o || error_o) && l < bound) begin
      @(negedge clk_i);
      l++;
    end
    to = !(done_o || error_o);
  endtask

  function automatic int model_latency();
    int s = SETTLE + 1;
    for (int i = 0; i < exp_q.size(); i++) s += 2 + wait_log[i];
    return s;
  endfunction

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    vectors++;
    if ({busy_o, done_o, error_o, apb.psel_o, apb.penable_o, apb.pwrite_o} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b, want 000000",
               {busy_o, done_o, error_o, apb.psel_o, apb.penable_o, apb.pwrite_o});
    end
    vectors++;
    if (apb.paddr_o !== 32'h0 || apb.pwdata_o !== 32'h0 || apb.pstrb_o !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_bus: got addr=%h wdata=%h strb=%h, want 0",
               apb.paddr_o, apb.pwdata_o, apb.pstrb_o);
    end
    rst_ni = 1'b1;
    psel_cycles = 0;
    repeat (5) @(negedge clk_i);
    vectors++;
    if (psel_cycles !== 0 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: got psel_cycles=%0d busy=%0b, want 0 0", psel_cycles, busy_o);
    end
  endtask

  task automatic test_basic();
    clear_obs();
    rand_wait = 1'b0; fixed_wait = 0; err_at = -1; rd_default = 32'h0;
    resp_q = {32'h0};
    rd_q = resp_q;
    build_exp(resp_q, 32'h0, -1, exp_done);
    pulse_start();
    wait_end(1, 3000, lat, tmo);
    vectors++;
    if (tmo) begin miscompares++; $display("FAIL basic_timeout: got busy after %0d cycles, want done", lat); end
    exp_lat = model_latency();
    vectors++;
    if (lat !== exp_lat) begin miscompares++; $display("FAIL basic_latency: got %0d, want %0d", lat, exp_lat); end
    vectors++;
    if ({done_o, busy_o, error_o} !== {exp_done, 2'b00}) begin
      miscompares++;
      $display("FAIL basic_flags: got done=%0b busy=%0b err=%0b, want %0b 0 0", done_o, busy_o, error_o, exp_done);
    end
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL basic_count: got %0d, want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i].wr !== exp_q[i].wr || obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
        miscompares++;
        $display("FAIL basic_xfer[%0d]: got wr=%0b addr=%h data=%h, want wr=%0b addr=%h data=%h", i,
                 obs_q[i].wr, obs_q[i].addr, obs_q[i].data, exp_q[i].wr, exp_q[i].addr, exp_q[i].data);
      end
    end
    vectors++;
    if (setup_cyc_q.size() < 4 || setup_cyc_q[3] - setup_cyc_q[2] != 2 + SETTLE) begin
      miscompares++;
      $display("FAIL basic_settle_gap: got %0d setups, want step3 setup %0d cycles after step2",
               setup_cyc_q.size(), 2 + SETTLE);
    end
    vectors++;
    if (psel_cycles != 2 * exp_q.size()) begin
      miscompares++; $display("FAIL basic_psel_cycles: got %0d, want %0d", psel_cycles, 2 * exp_q.size());
    end
  endtask

  task automatic test_wait_states();
    clear_obs();
    rand_wait = 1'b0; fixed_wait = 3; err_at = -1; rd_default = 32'h0;
    resp_q = {32'h0};
    rd_q = resp_q;
    build_exp(resp_q, 32'h0, -1, exp_done);
    pulse_start();
    wait_end(1, 3000, lat, tmo);
    exp_lat = model_latency();
    vectors++;
    if (tmo || lat !== exp_lat) begin
      miscompares++; $display("FAIL wait_latency: got %0d (timeout=%0b), want %0d", lat, tmo, exp_lat);
    end
    vectors++;
    if (done_o !== exp_done || error_o !== 1'b0) begin
      miscompares++; $display("FAIL wait_flags: got done=%0b err=%0b, want %0b 0", done_o, error_o, exp_done);
    end
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL wait_count: got %0d, want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i].wr !== exp_q[i].wr || obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
        miscompares++;
        $display("FAIL wait_xfer[%0d]: got addr=%h data=%h, want addr=%h data=%h", i,
                 obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data);
      end
    end
    fixed_wait = 0;
  endtask

  task automatic test_poll();
    int n;
    for (int it = 0; it < 7; it++) begin
      clear_obs();
      rand_wait = 1'b1; err_at = -1; rd_default = 32'h0;
      if (it == 0) begin
        resp_q = {32'h3, 32'h1, 32'h0};
      end else begin
        resp_q.delete();
        n = int'($urandom_range(0, POLL_LIMIT - 1));
        for (int k = 0; k < n; k++) resp_q.push_back($urandom | 32'h1);
        resp_q.push_back(32'h0);
      end
      rd_q = resp_q;
      build_exp(resp_q, 32'h0, -1, exp_done);
      pulse_start();
      wait_end(1, 3000, lat, tmo);
      exp_lat = model_latency();
      vectors++;
      if (tmo || lat !== exp_lat) begin
        miscompares++; $display("FAIL poll_latency[%0d]: got %0d, want %0d", it, lat, exp_lat);
      end
      vectors++;
      if (done_o !== exp_done || error_o !== 1'b0) begin
        miscompares++; $display("FAIL poll_flags[%0d]: got done=%0b err=%0b, want %0b 0", it, done_o, error_o, exp_done);
      end
      vectors++;
      if (obs_q.size() != exp_q.size()) begin
        miscompares++; $display("FAIL poll_count[%0d]: got %0d, want %0d", it, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        vectors++;
        if (obs_q[i].wr !== exp_q[i].wr || obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
          miscompares++;
          $display("FAIL poll_xfer[%0d][%0d]: got wr=%0b addr=%h data=%h, want wr=%0b addr=%h data=%h", it, i,
                   obs_q[i].wr, obs_q[i].addr, obs_q[i].data, exp_q[i].wr, exp_q[i].addr, exp_q[i].data);
        end
      end
    end
  endtask

  task automatic test_slverr();
    int snap;
    clear_obs();
    rand_wait = 1'b1; err_at = 1; rd_default = 32'h0;
    resp_q = {32'h0};
    rd_q = resp_q;
    build_exp(resp_q, 32'h0, 1, exp_done);
    pulse_start();
    wait_end(1, 3000, lat, tmo);
    vectors++;
    if ({error_o, done_o, busy_o} !== {~exp_done, exp_done, 1'b0}) begin
      miscompares++;
      $display("FAIL slverr_flags: got err=%0b done=%0b busy=%0b, want %0b %0b 0",
               error_o, done_o, busy_o, ~exp_done, exp_done);
    end
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL slverr_count: got %0d, want %0d", obs_q.size(), exp_q.size());
    end
    snap = psel_cycles;
    repeat (10) @(negedge clk_i);
    vectors++;
    if (psel_cycles != snap || error_o !== 1'b1) begin
      miscompares++;
      $display("FAIL slverr_quiet: got %0d extra psel cycles err=%0b, want 0 1", psel_cycles - snap, error_o);
    end
    clear_obs();
    err_at = -1;
    rd_q = resp_q;
    build_exp(resp_q, 32'h0, -1, exp_done);
    pulse_start();
    vectors++;
    if (error_o !== 1'b0 || busy_o !== 1'b1) begin
      miscompares++; $display("FAIL slverr_restart_flags: got err=%0b busy=%0b, want 0 1", error_o, busy_o);
    end
    wait_end(1, 3000, lat, tmo);
    vectors++;
    if (tmo || done_o !== 1'b1 || obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL slverr_restart_end: got done=%0b xfers=%0d, want 1 %0d", done_o, obs_q.size(), exp_q.size());
    end
    vectors++;
    if (obs_q.size() == 0 || obs_q[0].data !== 32'h300 || obs_q[0].addr !== CTRL_ADDR) begin
      miscompares++; $display("FAIL slverr_restart_first: got %0d xfers, want first write 300 at %h",
                              obs_q.size(), CTRL_ADDR);
    end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    rand_wait = 1'b0; fixed_wait = 0; err_at = -1; rd_default = 32'h0;
    resp_q = {32'h0};
    rd_q = resp_q;
    build_exp(resp_q, 32'h0, -1, exp_done);
    pulse_start();
    repeat (20) @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_end(22, 3000, lat, tmo);
    exp_lat = model_latency();
    vectors++;
    if (tmo || lat !== exp_lat || done_o !== 1'b1) begin
      miscompares++; $display("FAIL b2b_latency: got %0d done=%0b, want %0d 1", lat, done_o, exp_lat);
    end
    vectors++;
    if (obs_q.size() != exp_q.size() || setup_cyc_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d xfers %0d setups, want %0d", obs_q.size(), setup_cyc_q.size(), exp_q.size());
    end
  endtask

  task automatic test_timeout();
    int reads;
    int bad;
    clear_obs();
    rand_wait = 1'b1; err_at = -1; rd_q.delete(); rd_default = 32'h1;
    pulse_start();
`ifdef SERIAL_LINK_BOOT_SEQ_TIMEOUT_EN
    resp_q.delete();
    build_exp(resp_q, 32'h1, -1, exp_done);
    wait_end(1, 3000, lat, tmo);
    vectors++;
    if (tmo || error_o !== ~exp_done || done_o !== exp_done) begin
      miscompares++; $display("FAIL timeout_flags: got err=%0b done=%0b, want %0b %0b", error_o, done_o, ~exp_done, exp_done);
    end
    reads = obs_q.size() - 4;
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL timeout_reads: got %0d, want %0d", reads, exp_q.size() - 4);
    end
`else
    lat = 1;
    while (obs_q.size() < 104 && lat < 3000) begin
      @(negedge clk_i);
      lat++;
    end
    reads = obs_q.size() - 4;
    vectors++;
    if (reads < 100 || busy_o !== 1'b1 || done_o !== 1'b0 || error_o !== 1'b0) begin
      miscompares++;
      $display("FAIL poll_forever: got reads=%0d busy=%0b done=%0b err=%0b, want >=100 1 0 0",
               reads, busy_o, done_o, error_o);
    end
    bad = 0;
    for (int i = 4; i < obs_q.size(); i++)
      if (obs_q[i].wr !== 1'b0 || obs_q[i].addr !== ISO_ADDR) bad++;
    vectors++;
    if (bad != 0) begin
      miscompares++; $display("FAIL poll_forever_addr: got %0d bad reads, want 0", bad);
    end
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
`endif
    rd_default = 32'h0;
  endtask

  task automatic test_mid_reset();
    int n;
    clear_obs();
    rand_wait = 1'b1; err_at = -1; rd_default = 32'h0;
    resp_q = {32'h0};
    rd_q = resp_q;
    pulse_start();
    n = 0;
    while (!(apb.psel_o && apb.penable_o && setup_cyc_q.size() == 2) && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    vectors++;
    if (n >= 100) begin miscompares++; $display("FAIL midrst_reach: got no step1 access in %0d cycles, want one", n); end
    #1 rst_ni = 1'b0;
    #1;
    vectors++;
    if ({busy_o, done_o, error_o, apb.psel_o, apb.penable_o, apb.pwrite_o} !== 6'b0 ||
        apb.paddr_o !== 32'h0 || apb.pwdata_o !== 32'h0) begin
      miscompares++;
      $display("FAIL midrst_async: got psel=%0b pen=%0b busy=%0b addr=%h wdata=%h, want all 0",
               apb.psel_o, apb.penable_o, busy_o, apb.paddr_o, apb.pwdata_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    psel_cycles = 0;
    repeat (10) @(negedge clk_i);
    vectors++;
    if (psel_cycles != 0 || busy_o !== 1'b0) begin
      miscompares++; $display("FAIL midrst_quiet: got psel_cycles=%0d busy=%0b, want 0 0", psel_cycles, busy_o);
    end
    clear_obs();
    rd_q = resp_q;
    build_exp(resp_q, 32'h0, -1, exp_done);
    pulse_start();
    wait_end(1, 3000, lat, tmo);
    vectors++;
    if (tmo || done_o !== exp_done || obs_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL midrst_rerun: got done=%0b xfers=%0d, want %0b %0d",
                              done_o, obs_q.size(), exp_done, exp_q.size());
    end
    vectors++;
    if (obs_q.size() == 0 || obs_q[0].wr !== 1'b1 || obs_q[0].data !== 32'h300) begin
      miscompares++; $display("FAIL midrst_first: got %0d xfers, want first write 300", obs_q.size());
    end
  endtask

  initial begin
    apb.pready_i  = 1'b0;
    apb.prdata_i  = '0;
    apb.pslverr_i = 1'b0;
    test_reset();
    test_basic();
    test_wait_states();
    test_poll();
    test_slverr();
    test_back_to_back();
    test_timeout();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish by 2ms, want finish");
    $fatal(1);
  end
endmodule
